// File: rtl/inst_fetch.sv
// Instruction-fetch stage for the multicycle RV32I core: owns the PC, issues
// single outstanding imem requests, buffers one word for decode, handles redirects.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4,
  output logic        fetch_err
);

  typedef enum logic [1:0] {FETCH, WAIT, HOLD} state_t;

  state_t      state, state_d;
  logic [31:0] pc_q, pc_d;
  logic        drop_q, drop_d;
  logic        valid_d;
  logic [31:0] inst_d, idpc_d;
  logic        err_d;

  assign imem_req  = (state == FETCH) && !rst;
  assign imem_addr = {pc_q[31:2], 2'b00};
  assign id_pc4    = id_pc + 32'd4;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH;
      pc_q      <= RESET_PC;
      drop_q    <= 1'b0;
      id_valid  <= 1'b0;
      id_inst   <= NOP_INST;
      id_pc     <= '0;
      fetch_err <= 1'b0;
    end else begin
      state     <= state_d;
      pc_q      <= pc_d;
      drop_q    <= drop_d;
      id_valid  <= valid_d;
      id_inst   <= inst_d;
      id_pc     <= idpc_d;
      fetch_err <= err_d;
    end
  end

  always_comb begin
    state_d = state;
    pc_d    = pc_q;
    drop_d  = drop_q;
    valid_d = id_valid;
    inst_d  = id_inst;
    idpc_d  = id_pc;
    // A response can only legitimately arrive while waiting for one
    err_d   = fetch_err | (imem_rvalid && (state != WAIT));

    if (redirect) begin
      pc_d    = redirect_pc & ~32'h3;
      valid_d = 1'b0;
      inst_d  = NOP_INST;
      unique case (state)
        FETCH: begin
          drop_d  = 1'b1;
          state_d = WAIT;
        end
        WAIT: begin
          // A response arriving with the redirect is the stale one; consume it here
          if (imem_rvalid) begin
            drop_d  = 1'b0;
            state_d = FETCH;
          end else begin
            drop_d  = 1'b1;
          end
        end
        HOLD:    state_d = FETCH;
        default: state_d = FETCH;
      endcase
    end else begin
      unique case (state)
        FETCH: state_d = WAIT;
        WAIT: begin
          if (imem_rvalid) begin
            if (drop_q) begin
              drop_d  = 1'b0;
              state_d = FETCH;
            end else begin
              inst_d  = imem_rdata;
              idpc_d  = pc_q;
              valid_d = 1'b1;
              pc_d    = pc_q + 32'd4;
              state_d = HOLD;
            end
          end
        end
        HOLD: begin
          if (id_valid && id_ready) begin
            valid_d = 1'b0;
            inst_d  = NOP_INST;
            state_d = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

endmodule
